// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus bundle for apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the mirrored view.
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_STRB  = DATA_WIDTH / 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_STRB-1:0]  cmd_strb;
  logic [2:0]            cmd_prot;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            prot;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_STRB-1:0]  pstrb;
  logic                  pready;
  logic                  slverr;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  pready, slverr, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, prot, pwrite, psel, penable, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output pready, slverr, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, prot, pwrite, psel, penable, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready command port to APB requester: one command -> one SETUP/ACCESS transfer.
// Optional ACCESS wait-state timeout is built when APB_TIMEOUT_EN is defined.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_STRB      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               prstn_i,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [2:0]            prot_q;
  logic                  pwrite_q;
  logic                  psel_q;
  logic                  penable_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [DATA_STRB-1:0]  pstrb_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  assign bus.cmd_ready = (state_q == IDLE) && !prstn_i;
  assign bus.paddr     = paddr_q;
  assign bus.prot      = prot_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Transfer sequencer: IDLE accept, SETUP phase, ACCESS wait/complete, response pulse.
  always_ff @(posedge clk_i) begin
    if (prstn_i) begin
      state_q     <= IDLE;
      paddr_q     <= {ADDR_WIDTH{1'b0}};
      prot_q      <= 3'b000;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= {DATA_WIDTH{1'b0}};
      pstrb_q     <= {DATA_STRB{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
`ifdef APB_TIMEOUT_EN
      tmo_q       <= {TMO_W{1'b0}};
`endif
    end else begin
      // The response is a single-cycle pulse unless a branch below raises it.
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_addr[1:0] == 2'b00) begin
              paddr_q  <= bus.cmd_addr;
              prot_q   <= bus.cmd_prot;
              pwrite_q <= bus.cmd_write;
              pwdata_q <= bus.cmd_wdata;
              pstrb_q  <= bus.cmd_write ? bus.cmd_strb : {DATA_STRB{1'b0}};
              psel_q   <= 1'b1;
              state_q  <= SETUP;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_q     <= {TMO_W{1'b0}};
`endif
        end
        ACCESS: begin
          if (bus.pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.slverr;
            rsp_rdata_q <= (!pwrite_q && !bus.slverr) ? bus.prdata : {DATA_WIDTH{1'b0}};
            state_q     <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          // This is the TIMEOUT_CYCLES-th consecutive wait cycle: abandon the transfer.
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`else
          else begin
            state_q <= ACCESS;
          end
`endif
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge against a word-memory reference model.
module tb_apb_master_bridge;

  logic clk;
  logic prstn;
  int   n_total;
  int   n_bad;

  logic [31:0] slv_mem [64];
  logic [31:0] ref_mem [64];

  apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_master_bridge dut (
    .clk_i   (clk),
    .prstn_i (prstn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One command, start to finish; called just after a rising edge with the bridge idle.
  task automatic run_cmd(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input int nwait, input logic serr);
    logic [31:0] exp_rd;
    int idx;
    idx    = int'(addr[7:2]);
    exp_rd = (!w && !serr) ? ref_mem[idx] : 32'h0;
    if (w && !serr && addr[1:0] == 2'b00) ref_mem[idx] = merge(ref_mem[idx], wd, st);
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = addr;
    bus.cmd_wdata = wd;   bus.cmd_strb = st; bus.cmd_prot = pr;
    @(negedge clk);
    check_val("ready_idle", bus.cmd_ready, 1);
    check_val("rsp_quiet", bus.rsp_valid, 0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (addr[1:0] != 2'b00) begin
      @(negedge clk);
      check_val("mis_psel", bus.psel, 0);
      check_val("mis_rsp", bus.rsp_valid, 1);
      check_val("mis_err", bus.rsp_err, 1);
      check_val("mis_rdata", bus.rsp_rdata, 0);
      check_val("mis_ready", bus.cmd_ready, 1);
      @(posedge clk); #1;
      return;
    end
    @(negedge clk);
    check_val("setup_psel", bus.psel, 1);
    check_val("setup_pen", bus.penable, 0);
    check_val("setup_paddr", bus.paddr, addr);
    check_val("setup_pwrite", bus.pwrite, w);
    check_val("setup_pstrb", bus.pstrb, w ? st : 4'h0);
    check_val("setup_pwdata", bus.pwdata, wd);
    check_val("setup_prot", bus.prot, pr);
    for (int k = 0; k <= nwait; k++) begin
      @(negedge clk);
      check_val("acc_psel", bus.psel, 1);
      check_val("acc_pen", bus.penable, 1);
      check_val("acc_paddr", bus.paddr, addr);
      check_val("acc_pwdata", bus.pwdata, wd);
      check_val("acc_pstrb", bus.pstrb, w ? st : 4'h0);
      bus.pready = (k == nwait);
      bus.slverr = serr && (k == nwait);
      bus.prdata = (w || serr) ? $urandom : slv_mem[bus.paddr[7:2]];
      if (k == nwait && bus.pwrite && !serr)
        slv_mem[bus.paddr[7:2]] = merge(slv_mem[bus.paddr[7:2]], bus.pwdata, bus.pstrb);
      @(posedge clk); #1;
      bus.pready = 1'b0; bus.slverr = 1'b0; bus.prdata = 32'h0;
    end
    @(negedge clk);
    check_val("rsp_valid", bus.rsp_valid, 1);
    check_val("rsp_err", bus.rsp_err, serr);
    check_val("rsp_rdata", bus.rsp_rdata, exp_rd);
    check_val("rsp_psel", bus.psel, 0);
    check_val("rsp_pen", bus.penable, 0);
    check_val("rsp_ready", bus.cmd_ready, 1);
    check_val("rsp_paddr_hold", bus.paddr, addr);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] b_wd;
    logic [31:0] r_addr;
    int bi, nrsp, last, cnt;
    logic acc, got;
    n_total = 0; n_bad = 0;
    for (int i = 0; i < 64; i++) begin slv_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    prstn = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_wdata = 32'h0;
    bus.cmd_strb = 4'h0; bus.cmd_prot = 3'h0; bus.pready = 1'b0; bus.slverr = 1'b0; bus.prdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", bus.cmd_ready, 0);
    check_val("rst_psel", bus.psel, 0);
    check_val("rst_pen", bus.penable, 0);
    check_val("rst_paddr", bus.paddr, 0);
    check_val("rst_rsp", bus.rsp_valid, 0);
    check_val("rst_pwdata", bus.pwdata, 0);
    @(posedge clk); #1;
    prstn = 1'b0;

    run_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h2, 0, 1'b0);
    run_cmd(1'b0, 32'h10, 32'h0, 4'hF, 3'h0, 0, 1'b0);
    run_cmd(1'b1, 32'h14, 32'h12345678, 4'h5, 3'h1, 3, 1'b0);
    run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3'h0, 1, 1'b1);
    run_cmd(1'b1, 32'h12, 32'hCAFEF00D, 4'hF, 3'h0, 0, 1'b0);

    // 16 back-to-back full-word writes with cmd_valid held and pready tied high.
    bus.pready = 1'b1; bus.slverr = 1'b0;
    bi = 0; nrsp = 0; last = -1;
    b_wd = $urandom;
    bus.cmd_write = 1'b1; bus.cmd_addr = 32'h0; bus.cmd_wdata = b_wd; bus.cmd_strb = 4'hF;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 120 && nrsp < 16; c++) begin
      @(negedge clk);
      if (bus.psel && bus.penable)
        slv_mem[bus.paddr[7:2]] = merge(slv_mem[bus.paddr[7:2]], bus.pwdata, bus.pstrb);
      if (bus.rsp_valid) begin
        nrsp++; last = c;
        check_val("b2b_ready", bus.cmd_ready, 1);
        check_val("b2b_err", bus.rsp_err, 0);
      end
      acc = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      if (acc) begin
        ref_mem[bi] = b_wd;
        bi++;
        if (bi == 16) bus.cmd_valid = 1'b0;
        else begin
          b_wd = $urandom;
          bus.cmd_addr = 32'(4 * bi); bus.cmd_wdata = b_wd;
        end
      end
    end
    bus.pready = 1'b0;
    check_val("b2b_count", nrsp, 16);
    check_val("b2b_cycles", last, 48);

    // Reset asserted during ACCESS: transfer dropped, no response.
    bus.cmd_write = 1'b1; bus.cmd_addr = 32'h20; bus.cmd_wdata = 32'h55AA55AA; bus.cmd_strb = 4'hF;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("mid_acc_pen", bus.penable, 1);
    prstn = 1'b1;
    @(posedge clk); #1;
    prstn = 1'b0;
    @(negedge clk);
    check_val("mid_rst_psel", bus.psel, 0);
    check_val("mid_rst_pen", bus.penable, 0);
    check_val("mid_rst_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    check_val("mid_rst_rsp2", bus.rsp_valid, 0);
    check_val("mid_rst_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;

`ifdef APB_TIMEOUT_EN
    // pready never rises: expect 16 ACCESS cycles, then an error response.
    bus.cmd_write = 1'b0; bus.cmd_addr = 32'h30; bus.cmd_valid = 1'b1; bus.prdata = 32'hFFFF0000;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    cnt = 0; got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (bus.penable) cnt++;
      if (bus.rsp_valid) begin
        got = 1'b1;
        check_val("tmo_err", bus.rsp_err, 1);
        check_val("tmo_rdata", bus.rsp_rdata, 0);
      end
    end
    check_val("tmo_seen", got, 1);
    check_val("tmo_len", cnt, 16);
    bus.prdata = 32'h0;
    @(posedge clk); #1;
    run_cmd(1'b0, 32'h0, 32'h0, 4'h0, 3'h0, 15, 1'b0);
`else
    cnt = 0; got = 1'b0;
`endif

    for (int i = 0; i < 40; i++) begin
      r_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
      run_cmd(1'($urandom), r_addr, $urandom, 4'($urandom), 3'($urandom),
              $urandom_range(0, 4), ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester that drives our apb_slave from a simple valid/ready command port.
- Converts one command into one APB SETUP/ACCESS transfer and returns read data and error status as a one-cycle response pulse.
- Sits between the test or sequencer logic and the apb_slave, and replaces hand-timed pin wiggling on the APB signals.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and paddr.
- DATA_WIDTH, 32, width of write/read data; must be a multiple of 8.
- DATA_STRB, DATA_WIDTH/8, byte-strobe width.
- TIMEOUT_CYCLES, 16, ACCESS wait-state limit; used only with APB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- prstn  in  1  reset, synchronous, active-high (port name retained, polarity fixed as stated).
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_STRB  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes/errors).
- rsp_err  out  1  slverr, misalignment or timeout.
- paddr  out  ADDR_WIDTH; prot  out  3; pwrite  out  1; psel  out  1; penable  out  1; pwdata  out  DATA_WIDTH; pstrb  out  DATA_STRB  APB requester outputs.
- pready  in  1; slverr  in  1; prdata  in  DATA_WIDTH  APB completer inputs.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While prstn=1 at a clk edge, all outputs go to 0, state goes to IDLE and the timeout counter clears.
- Reset mid-transfer: psel/penable drop at the next edge, the transfer is discarded and no rsp_valid is produced.
- FSM states are IDLE, SETUP, ACCESS. cmd_ready = (state==IDLE) && !prstn, combinational.
- IDLE: on accept with cmd_addr[1:0]==0, register the address, attributes and data into the APB outputs and go to SETUP.
  - pstrb = cmd_strb on writes, forced 0 on reads.
- SETUP (1 cycle): psel=1, penable=0. Go to ACCESS.
- ACCESS: psel=1, penable=1. All APB outputs are held stable.
  - If pready is sampled 1, go to IDLE. Next cycle: psel=penable=0, rsp_valid=1, rsp_err=slverr, rsp_rdata = (read && !slverr) ? prdata : 0.
  - If pready is sampled 0, stay in ACCESS (wait state).
- Misaligned accept (cmd_addr[1:0]!=0): no APB transfer, stay in IDLE. Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0, and cmd_ready stays 1.
- Latency, zero wait states: accept at edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid in N+3. Peak throughput is one transfer per 3 cycles; a new command can be accepted in the same cycle that rsp_valid=1.
- paddr/pwdata/pwrite/prot hold their last value after a transfer completes (no forced 0 outside reset).
- rsp_valid is never high for two consecutive cycles from a single command. rsp_rdata/rsp_err are valid only while rsp_valid=1.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES with pready still 0, the transfer is aborted: go to IDLE, psel=penable=0, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - pready=1 in the same cycle as the limit wins: the transfer completes normally.
- APB_TIMEOUT_EN undefined: no counter logic is built and ACCESS waits indefinitely for pready.

Test Plan:
- Write 0xDEADBEEF to 0x00000010 with strb 4'b1111 and pready tied 1 -> psel rises at N+1, penable at N+2, pwrite=1, pstrb=4'hF; rsp_valid at N+3 with rsp_err=0.
- Read 0x00000010 after that write (slave returns 0xDEADBEEF) -> pstrb=0, pwrite=0, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write with pready low for 3 ACCESS cycles -> penable high for 4 cycles, APB outputs stable, single rsp_valid 1 cycle after pready.
- Read with slverr=1 at completion -> rsp_err=1, rsp_rdata=0. Misaligned command to 0x00000012 -> no psel, rsp_err=1 next cycle.
- 16 back-to-back writes to 0x0+4i, cmd_valid held 1 -> 16 transfers, 48 cycles total, cmd_ready high in each response cycle.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and pready stuck 0 -> abort after 16 wait cycles with rsp_err=1. Assert prstn during ACCESS -> psel=0 next edge and no rsp_valid.
